// File: rtl/cdc_handshake_tx.sv
// Four-phase request/acknowledge transmitter: launches a registered payload into a remote clock domain.
// Define CDC_HANDSHAKE_TX_TIMEOUT_EN to add TIMEOUT_CYCLES and the Error_o abort path.
module cdc_handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1023
`endif
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Data_i,
    output logic             Busy_o,
    output logic             Done_o,
    output logic             Req_o,
    output logic [WIDTH-1:0] Data_o,
    input  logic             Ack_i
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    ,
    output logic             Error_o
`endif
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic                   reqNext;
    logic [WIDTH-1:0]       dataNext;
    logic                   doneNext;
    logic [SYNC_STAGES-1:0] ackSync;
    logic                   ackS;

    // Only the last stage of the chain is trusted; earlier stages may be metastable.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ackSync <= '0;
        end else begin
            ackSync <= {ackSync[SYNC_STAGES-2:0], Ack_i};
        end
    end

    assign ackS   = ackSync[SYNC_STAGES-1];
    assign Busy_o = (state != IDLE) || ackS;

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] timeoutCount;
    logic [CW-1:0] timeoutCountNext;
    logic          errorNext;
`endif

    always_comb begin
        stateNext = state;
        reqNext   = Req_o;
        dataNext  = Data_o;
        doneNext  = 1'b0;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        errorNext = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (Start_i && !ackS) begin
                    dataNext  = Data_i;
                    reqNext   = 1'b1;
                    stateNext = WAIT_ACK_HI;
                end
            end
            WAIT_ACK_HI: begin
                if (ackS) begin
                    reqNext   = 1'b0;
                    stateNext = WAIT_ACK_LO;
                end
            end
            WAIT_ACK_LO: begin
                if (!ackS) begin
                    doneNext  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: begin
                reqNext   = 1'b0;
                stateNext = IDLE;
            end
        endcase
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        // A normal handshake step on the same edge takes precedence over the abort.
        if ((stateNext == state) && (state != IDLE) && (timeoutCount == CW'(TIMEOUT_CYCLES))) begin
            reqNext   = 1'b0;
            stateNext = IDLE;
            errorNext = 1'b1;
        end
        if (stateNext != state) begin
            timeoutCountNext = '0;
        end else if (state != IDLE) begin
            timeoutCountNext = timeoutCount + CW'(1);
        end else begin
            timeoutCountNext = '0;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= IDLE;
            Req_o  <= 1'b0;
            Data_o <= '0;
            Done_o <= 1'b0;
        end else begin
            state  <= stateNext;
            Req_o  <= reqNext;
            Data_o <= dataNext;
            Done_o <= doneNext;
        end
    end

`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            timeoutCount <= '0;
            Error_o      <= 1'b0;
        end else begin
            timeoutCount <= timeoutCountNext;
            Error_o      <= errorNext;
        end
    end
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed, table-driven bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=2).
// Define CDC_HANDSHAKE_TX_TIMEOUT_EN to also exercise the timeout abort with TIMEOUT_CYCLES=15.
module tb_cdc_handshake_tx;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start_i;
    logic [7:0] Data_i;
    logic       Ack_i;
    logic       Busy_o;
    logic       Done_o;
    logic       Req_o;
    logic [7:0] Data_o;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
    logic       Error_o;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       reset;
        logic       start;
        logic [7:0] data;
        logic       ack;
        logic       expReq;
        logic [7:0] expData;
        logic       expBusy;
        logic       expDone;
    } vec_t;

    vec_t vecs[$];

    cdc_handshake_tx #(
        .WIDTH(8),
        .SYNC_STAGES(2)
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(15)
`endif
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Start_i(Start_i),
        .Data_i(Data_i),
        .Busy_o(Busy_o),
        .Done_o(Done_o),
        .Req_o(Req_o),
        .Data_o(Data_o),
        .Ack_i(Ack_i)
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        ,
        .Error_o(Error_o)
`endif
    );

    always #5 Clock = ~Clock;

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic applyStimulus(input logic rst, input logic start, input logic [7:0] data, input logic ack);
        Reset   = rst;
        Start_i = start;
        Data_i  = data;
        Ack_i   = ack;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic start, input logic [7:0] data, input logic ack,
                                input logic req, input logic [7:0] dOut, input logic busy, input logic done);
        vec_t v;
        v.reset = rst; v.start = start; v.data = data; v.ack = ack;
        v.expReq = req; v.expData = dOut; v.expBusy = busy; v.expDone = done;
        return v;
    endfunction

    initial begin
        int doneCount;
        int errAt;
        int errCount;
        int reqDrops;
        logic reqAtErr;

        Reset = 1'b1; Start_i = 1'b0; Data_i = 8'h00; Ack_i = 1'b0;

        // Entry k is edge k+1 after reset release.
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 1
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 0, 0)); // 2  ack toggles in IDLE
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h00, 1, 0)); // 3
        vecs.push_back(mk(0, 1, 8'h77, 0,  0, 8'h00, 1, 0)); // 4  start blocked by ackS
        vecs.push_back(mk(0, 1, 8'h77, 0,  0, 8'h00, 0, 0)); // 5
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 6
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 7
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 8
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 9
        vecs.push_back(mk(0, 1, 8'hA5, 0,  1, 8'hA5, 1, 0)); // 10 accepted
        vecs.push_back(mk(0, 0, 8'h00, 0,  1, 8'hA5, 1, 0)); // 11
        vecs.push_back(mk(0, 1, 8'h3C, 0,  1, 8'hA5, 1, 0)); // 12 ignored in WAIT_ACK_HI
        vecs.push_back(mk(0, 0, 8'h00, 0,  1, 8'hA5, 1, 0)); // 13
        vecs.push_back(mk(0, 0, 8'h00, 0,  1, 8'hA5, 1, 0)); // 14
        vecs.push_back(mk(0, 0, 8'h00, 1,  1, 8'hA5, 1, 0)); // 15 ack raised after 14
        vecs.push_back(mk(0, 0, 8'h00, 1,  1, 8'hA5, 1, 0)); // 16
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'hA5, 1, 0)); // 17 req falls
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'hA5, 1, 0)); // 18
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'hA5, 1, 0)); // 19
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'hA5, 1, 0)); // 20
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'hA5, 1, 0)); // 21 ack dropped after 20
        vecs.push_back(mk(0, 1, 8'h11, 0,  0, 8'hA5, 1, 0)); // 22 start ignored in WAIT_ACK_LO
        vecs.push_back(mk(0, 1, 8'h11, 0,  0, 8'hA5, 0, 1)); // 23 done
        vecs.push_back(mk(0, 1, 8'h11, 0,  1, 8'h11, 1, 0)); // 24 back-to-back accept
        vecs.push_back(mk(0, 0, 8'h00, 0,  1, 8'h11, 1, 0)); // 25
        vecs.push_back(mk(0, 0, 8'h00, 1,  1, 8'h11, 1, 0)); // 26
        vecs.push_back(mk(0, 0, 8'h00, 1,  1, 8'h11, 1, 0)); // 27
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h11, 1, 0)); // 28
        vecs.push_back(mk(0, 0, 8'h00, 1,  0, 8'h11, 1, 0)); // 29 WAIT_ACK_LO
        vecs.push_back(mk(1, 0, 8'h00, 1,  0, 8'h00, 0, 0)); // 30 reset mid-handshake
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 31
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 32
        vecs.push_back(mk(0, 1, 8'hC3, 0,  1, 8'hC3, 1, 0)); // 33 accepted after reset
        vecs.push_back(mk(1, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 34 reset in WAIT_ACK_HI
        vecs.push_back(mk(0, 0, 8'h00, 0,  0, 8'h00, 0, 0)); // 35

        // Reset must override a simultaneous start and a high acknowledge.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
            checkOutput($sformatf("reset%0d req", i), 64'(Req_o), 64'd0);
            checkOutput($sformatf("reset%0d data", i), 64'(Data_o), 64'h00);
            checkOutput($sformatf("reset%0d busy", i), 64'(Busy_o), 64'd0);
            checkOutput($sformatf("reset%0d done", i), 64'(Done_o), 64'd0);
        end

        doneCount = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].reset, vecs[i].start, vecs[i].data, vecs[i].ack);
            if (Done_o === 1'b1) doneCount++;
            checkOutput($sformatf("e%0d req", i + 1), 64'(Req_o), 64'(vecs[i].expReq));
            checkOutput($sformatf("e%0d data", i + 1), 64'(Data_o), 64'(vecs[i].expData));
            checkOutput($sformatf("e%0d busy", i + 1), 64'(Busy_o), 64'(vecs[i].expBusy));
            checkOutput($sformatf("e%0d done", i + 1), 64'(Done_o), 64'(vecs[i].expDone));
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
            checkOutput($sformatf("e%0d error", i + 1), 64'(Error_o), 64'd0);
`endif
        end
        checkOutput("table done count", 64'(doneCount), 64'd1);

        // Start a transfer that never sees an acknowledge.
        applyStimulus(1'b0, 1'b1, 8'hE7, 1'b0);
        checkOutput("stall req rise", 64'(Req_o), 64'd1);
        checkOutput("stall data", 64'(Data_o), 64'hE7);
        doneCount = 0;
        errAt     = 0;
        errCount  = 0;
        reqDrops  = 0;
        reqAtErr  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
            if (Done_o === 1'b1) doneCount++;
            if (Req_o !== 1'b1) reqDrops++;
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
            if (Error_o === 1'b1) begin
                errCount++;
                if (errAt == 0) begin
                    errAt    = i;
                    reqAtErr = Req_o;
                end
            end
`endif
        end
        checkOutput("stall done count", 64'(doneCount), 64'd0);
`ifdef CDC_HANDSHAKE_TX_TIMEOUT_EN
        checkOutput("timeout error edge", 64'(errAt), 64'd16);
        checkOutput("timeout error count", 64'(errCount), 64'd1);
        checkOutput("timeout req at error", 64'(reqAtErr), 64'd0);
        checkOutput("timeout busy after", 64'(Busy_o), 64'd0);
`else
        checkOutput("stall req held", 64'(reqDrops), 64'd0);
        checkOutput("stall busy held", 64'(Busy_o), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
